arena_engine: RTL and testbench
===============================

Name: arena_engine

Overview:
- Game-arena helper that sits beside the player-drawing stage.
- Combinationally flags, per direction, whether moving the player one pixel would hit a fixed wall.
- Maintains a collectible point, registered and re-placed pseudo-randomly when the player touches it.
- The drawing stage consumes collision_* to gate movement and point_x/point_y to render the point.

Parameters:
- SCREEN_W, 800, active width in pixels.
- SCREEN_H, 600, active height in pixels.
- PLAYER_SIZE, 16, player half-size; box spans [pos-PLAYER_SIZE+1, pos+PLAYER_SIZE] on each axis.
- POINT_SIZE, 8, point half-size; same box convention as the player.
- INIT_X, 400, point_x after reset.
- INIT_Y, 200, point_y after reset.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- xpos  in  10  player centre x
- ypos  in  10  player centre y
- collision_up  out  1  moving y-1 would overlap a wall
- collision_down  out  1  moving y+1 would overlap a wall
- collision_right  out  1  moving x+1 would overlap a wall
- collision_left  out  1  moving x-1 would overlap a wall
- point_x  out  10  point centre x, registered
- point_y  out  10  point centre y, registered
- point_hit  out  1  one-cycle pulse when a hit is detected
- score  out  8  hit count (see Optional Feature)

Behaviour:
- Walls are fixed inclusive rectangles (x0..x1, y0..y1):
  - W0: 200..215, 100..399
  - W1: 400..599, 300..315
  - W2: 600..615, 50..249
- Overlap of inclusive intervals [a0,a1] and [b0,b1]: a0<=b1 and b0<=a1. Boxes overlap when both axes overlap.
- All box arithmetic is 12-bit signed, so xpos<PLAYER_SIZE yields negative bounds with no wrap.
- Collision outputs are purely combinational (zero latency) and unaffected by clk/rst. Each is asserted if the shifted player box overlaps any wall:
  - up: y range [ypos-PS, ypos+PS-1], x unchanged
  - down: y range [ypos-PS+2, ypos+PS+1], x unchanged
  - left: x range [xpos-PS, xpos+PS-1], y unchanged
  - right: x range [xpos-PS+2, xpos+PS+1], y unchanged
  - Screen edges are not collisions here.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11 (feedback = b15^b13^b12^b10, shifted in at bit 0).
  - Advances every cycle.
  - Reset value LFSR_SEED.
- Candidate point: cx = lfsr[9:0], cy = lfsr[15:6]. A candidate is valid iff all of:
  - cx>=POINT_SIZE-1 and cx+POINT_SIZE<=SCREEN_W-1
  - cy>=POINT_SIZE-1 and cy+POINT_SIZE<=SCREEN_H-1
  - its box overlaps no wall
  - its box does not overlap the current player box
- hit (combinational) = player box overlaps the current point box.
- FSM IDLE/SEARCH, all outputs registered:
  - Reset: state IDLE, point=(INIT_X,INIT_Y), point_hit=0, score=0, lfsr=seed.
  - IDLE: hit=1 at an edge → state SEARCH, point_hit=1 for exactly that next cycle, score increments.
  - SEARCH: hit is ignored and point holds its old value. At the first edge with a valid candidate, point<=candidate and state→IDLE. Otherwise retry on the next LFSR value.
  - Re-entry to SEARCH requires a new hit evaluated in IDLE. If the player remains on the new point, this re-hits immediately, which is acceptable; the new point cannot overlap the player at placement time.
- rst mid-SEARCH aborts the search and restores the reset values.

Optional Feature:
- Macro ARENA_SCORE_EN.
- Defined: score is an 8-bit counter incremented on each IDLE→SEARCH transition, saturating at 255 and cleared by rst.
- Undefined: score is tied to 0 and no counter logic is instantiated; all other behaviour is identical.

Test Plan:
- Reset: assert rst 2 cycles with player (32,32) → point=(400,200), point_hit=0, score=0, all collision_*=0.
- Right wall: ypos=200. xpos=182 → collision_right=0. xpos=183 → collision_right=1, others 0.
- Up wall: xpos=200. ypos=416 → collision_up=0. ypos=415 → collision_up=1 (W0 bottom edge y=399).
- Hit and relocate: after reset set player (400,200).
  - point_hit=1 for exactly one cycle.
  - Within 64 cycles point changes to a valid position: inside the screen by POINT_SIZE, not overlapping W0–W2 or the player box.
  - score=1 with ARENA_SCORE_EN.
- Reset mid-search: trigger a hit, assert rst during SEARCH → point returns to (400,200), FSM in IDLE, score=0.
- Saturation (ARENA_SCORE_EN): force 260 hits → score=255.

Source files
------------

// File: rtl/arena_engine.sv
// Arena helper: per-direction wall collision flags, plus a collectible point that is re-placed
// pseudo-randomly after each hit. Define ARENA_SCORE_EN to enable the saturating hit counter.
module arena_engine #(
  parameter int          SCREEN_W    = 800,
  parameter int          SCREEN_H    = 600,
  parameter int          PLAYER_SIZE = 16,
  parameter int          POINT_SIZE  = 8,
  parameter int          INIT_X      = 400,
  parameter int          INIT_Y      = 200,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] xpos,
  input  logic [9:0] ypos,
  output logic       collision_up,
  output logic       collision_down,
  output logic       collision_right,
  output logic       collision_left,
  output logic [9:0] point_x,
  output logic [9:0] point_y,
  output logic       point_hit,
  output logic [7:0] score
);

  typedef logic signed [11:0] coord_t;

  localparam coord_t PS  = coord_t'(PLAYER_SIZE);
  localparam coord_t PTS = coord_t'(POINT_SIZE);
  localparam coord_t SW  = coord_t'(SCREEN_W);
  localparam coord_t SH  = coord_t'(SCREEN_H);
  localparam coord_t ONE = 12'sd1;
  localparam coord_t TWO = 12'sd2;

  function automatic logic overlap(coord_t a0, coord_t a1, coord_t b0, coord_t b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  function automatic logic hits_wall(coord_t x0, coord_t x1, coord_t y0, coord_t y1);
    return (overlap(x0, x1, 12'sd200, 12'sd215) && overlap(y0, y1, 12'sd100, 12'sd399)) ||
           (overlap(x0, x1, 12'sd400, 12'sd599) && overlap(y0, y1, 12'sd300, 12'sd315)) ||
           (overlap(x0, x1, 12'sd600, 12'sd615) && overlap(y0, y1, 12'sd50,  12'sd249));
  endfunction

  typedef enum logic [0:0] {StIdle, StSearch} state_e;

  state_e      state_q, state_d;
  logic [15:0] lfsr_q;
  logic [9:0]  point_x_q, point_x_d;
  logic [9:0]  point_y_q, point_y_d;
  logic        point_hit_q, point_hit_d;

  // Player box; zero-extended to 12-bit signed so boxes near the origin go negative.
  coord_t px, py, pl_x0, pl_x1, pl_y0, pl_y1;
  assign px    = $signed({2'b00, xpos});
  assign py    = $signed({2'b00, ypos});
  assign pl_x0 = px - PS + ONE;
  assign pl_x1 = px + PS;
  assign pl_y0 = py - PS + ONE;
  assign pl_y1 = py + PS;

  assign collision_up    = hits_wall(pl_x0, pl_x1, py - PS, py + PS - ONE);
  assign collision_down  = hits_wall(pl_x0, pl_x1, py - PS + TWO, py + PS + ONE);
  assign collision_left  = hits_wall(px - PS, px + PS - ONE, pl_y0, pl_y1);
  assign collision_right = hits_wall(px - PS + TWO, px + PS + ONE, pl_y0, pl_y1);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  coord_t cx, cy, c_x0, c_x1, c_y0, c_y1;
  logic   cand_valid;
  assign cx   = $signed({2'b00, lfsr_q[9:0]});
  assign cy   = $signed({2'b00, lfsr_q[15:6]});
  assign c_x0 = cx - PTS + ONE;
  assign c_x1 = cx + PTS;
  assign c_y0 = cy - PTS + ONE;
  assign c_y1 = cy + PTS;

  assign cand_valid = (cx >= PTS - ONE) && (cx + PTS <= SW - ONE) &&
                      (cy >= PTS - ONE) && (cy + PTS <= SH - ONE) &&
                      !hits_wall(c_x0, c_x1, c_y0, c_y1) &&
                      !(overlap(c_x0, c_x1, pl_x0, pl_x1) && overlap(c_y0, c_y1, pl_y0, pl_y1));

  coord_t ptx, pty;
  logic   hit;
  assign ptx = $signed({2'b00, point_x_q});
  assign pty = $signed({2'b00, point_y_q});
  assign hit = overlap(pl_x0, pl_x1, ptx - PTS + ONE, ptx + PTS) &&
               overlap(pl_y0, pl_y1, pty - PTS + ONE, pty + PTS);

  always_comb begin
    state_d     = state_q;
    point_x_d   = point_x_q;
    point_y_d   = point_y_q;
    point_hit_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (hit) begin
          state_d     = StSearch;
          point_hit_d = 1'b1;
        end
      end
      StSearch: begin
        // Hits are ignored here; the old point stays visible until a valid candidate appears.
        if (cand_valid) begin
          state_d   = StIdle;
          point_x_d = lfsr_q[9:0];
          point_y_d = lfsr_q[15:6];
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      point_x_q   <= 10'(INIT_X);
      point_y_q   <= 10'(INIT_Y);
      point_hit_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      point_x_q   <= point_x_d;
      point_y_q   <= point_y_d;
      point_hit_q <= point_hit_d;
    end
  end

  assign point_x   = point_x_q;
  assign point_y   = point_y_q;
  assign point_hit = point_hit_q;

`ifdef ARENA_SCORE_EN
  logic [7:0] score_q;
  // point_hit_d is high exactly on the IDLE->SEARCH transition.
  always_ff @(posedge clk) begin
    if (rst) begin
      score_q <= 8'd0;
    end else if (point_hit_d && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end
  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule

// File: tb/tb_arena_engine.sv
// Directed bench for arena_engine: collision vector table plus hit/relocate, reset-abort and
// score sequences, with a reference LFSR to predict the relocated point.
module tb_arena_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] xpos = 10'd32;
  logic [9:0] ypos = 10'd32;
  logic       collision_up, collision_down, collision_right, collision_left;
  logic [9:0] point_x, point_y;
  logic       point_hit;
  logic [7:0] score;

  arena_engine dut (
    .clk            (clk),
    .rst            (rst),
    .xpos           (xpos),
    .ypos           (ypos),
    .collision_up   (collision_up),
    .collision_down (collision_down),
    .collision_right(collision_right),
    .collision_left (collision_left),
    .point_x        (point_x),
    .point_y        (point_y),
    .point_hit      (point_hit),
    .score          (score)
  );

  always #5 clk = ~clk;

  // Reference LFSR: m_prev is the value the DUT saw at the most recent edge.
  logic [15:0] m_lfsr, m_prev;
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    m_lfsr <= rst ? 16'hACE1 : {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic bit ov(int a0, int a1, int b0, int b1);
    return (a0 <= b1) && (b0 <= a1);
  endfunction

  function automatic bit in_wall(int x0, int x1, int y0, int y1);
    return (ov(x0, x1, 200, 215) && ov(y0, y1, 100, 399)) ||
           (ov(x0, x1, 400, 599) && ov(y0, y1, 300, 315)) ||
           (ov(x0, x1, 600, 615) && ov(y0, y1, 50, 249));
  endfunction

  function automatic bit cand_ok(int cx, int cy, int px, int py);
    if (cx < 7 || cx + 8 > 799 || cy < 7 || cy + 8 > 599) return 1'b0;
    if (in_wall(cx - 7, cx + 8, cy - 7, cy + 8)) return 1'b0;
    if (ov(cx - 7, cx + 8, px - 15, px + 16) && ov(cy - 7, cy + 8, py - 15, py + 16)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic do_reset(input int px, input int py);
    @(negedge clk);
    rst = 1'b1;
    xpos = 10'(px);
    ypos = 10'(py);
    repeat (2) @(negedge clk);
  endtask

  typedef struct {
    int x;
    int y;
    bit up;
    bit down;
    bit left;
    bit right;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int  cand_x, cand_y, old_x, old_y, nhits, exp_score;
    bit  moved, ok;

    vecs[0] = '{x: 182, y: 200, up: 0, down: 0, left: 0, right: 0};
    vecs[1] = '{x: 183, y: 200, up: 0, down: 0, left: 0, right: 1};
    vecs[2] = '{x: 200, y: 416, up: 0, down: 0, left: 0, right: 0};
    vecs[3] = '{x: 200, y: 415, up: 1, down: 0, left: 0, right: 0};
    vecs[4] = '{x: 231, y: 200, up: 0, down: 0, left: 1, right: 0};
    vecs[5] = '{x: 232, y: 200, up: 0, down: 0, left: 0, right: 0};
    vecs[6] = '{x: 500, y: 283, up: 0, down: 1, left: 0, right: 0};
    vecs[7] = '{x: 500, y: 282, up: 0, down: 0, left: 0, right: 0};
    vecs[8] = '{x: 608, y: 265, up: 1, down: 0, left: 0, right: 0};
    vecs[9] = '{x: 184, y: 84,  up: 0, down: 1, left: 0, right: 1};

    // Reset state
    do_reset(32, 32);
    check("rst_point_x", int'(point_x), 400);
    check("rst_point_y", int'(point_y), 200);
    check("rst_point_hit", int'(point_hit), 0);
    check("rst_score", int'(score), 0);
    check("rst_collisions",
          int'({collision_up, collision_down, collision_left, collision_right}), 0);
    rst = 1'b0;

    // Combinational collision table; also near-origin negative bounds
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      xpos = 10'(vecs[i].x);
      ypos = 10'(vecs[i].y);
      #1;
      check($sformatf("vec%0d_up", i), int'(collision_up), int'(vecs[i].up));
      check($sformatf("vec%0d_down", i), int'(collision_down), int'(vecs[i].down));
      check($sformatf("vec%0d_left", i), int'(collision_left), int'(vecs[i].left));
      check($sformatf("vec%0d_right", i), int'(collision_right), int'(vecs[i].right));
    end
    @(negedge clk);
    xpos = 10'd5;
    ypos = 10'd5;
    #1;
    check("origin_collisions",
          int'({collision_up, collision_down, collision_left, collision_right}), 0);

    // Hit and relocate
    do_reset(32, 32);
    rst  = 1'b0;
    xpos = 10'd400;
    ypos = 10'd200;
    @(posedge clk);
    #1;
    check("hit_pulse", int'(point_hit), 1);
    check("hit_hold_x", int'(point_x), 400);
    moved = 1'b0;
    for (int c = 0; c < 64 && !moved; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) check("hit_pulse_end", int'(point_hit), 0);
      cand_x = int'(m_prev[9:0]);
      cand_y = int'(m_prev[15:6]);
      if (point_x != 10'd400 || point_y != 10'd200) begin
        moved = 1'b1;
        check("reloc_x", int'(point_x), cand_x);
        check("reloc_y", int'(point_y), cand_y);
        check("reloc_valid", int'(cand_ok(int'(point_x), int'(point_y), 400, 200)), 1);
      end else begin
        check($sformatf("skip_invalid_c%0d", c), int'(cand_ok(cand_x, cand_y, 400, 200)), 0);
      end
    end
    check("reloc_in_time", int'(moved), 1);
    @(posedge clk);
    #1;
    check("no_rehit", int'(point_hit), 0);
`ifdef ARENA_SCORE_EN
    check("score_one", int'(score), 1);
`else
    check("score_tied", int'(score), 0);
`endif

    // Reset during SEARCH
    do_reset(32, 32);
    rst  = 1'b0;
    xpos = 10'd400;
    ypos = 10'd200;
    @(posedge clk);
    #1;
    check("abort_hit", int'(point_hit), 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("abort_point_x", int'(point_x), 400);
    check("abort_point_y", int'(point_y), 200);
    check("abort_point_hit", int'(point_hit), 0);
    check("abort_score", int'(score), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("abort_idle_rehit", int'(point_hit), 1);

    // Repeated hits; score saturates when enabled
`ifdef ARENA_SCORE_EN
    nhits = 260;
    exp_score = 255;
`else
    nhits = 3;
    exp_score = 0;
`endif
    do_reset(32, 32);
    rst = 1'b0;
    ok  = 1'b1;
    for (int k = 0; k < nhits && ok; k++) begin
      @(negedge clk);
      xpos  = point_x;
      ypos  = point_y;
      old_x = int'(point_x);
      old_y = int'(point_y);
      moved = 1'b0;
      for (int c = 0; c < 4 && !moved; c++) begin
        @(posedge clk);
        #1;
        moved = point_hit;
      end
      if (!moved) ok = 1'b0;
      moved = 1'b0;
      for (int c = 0; c < 64 && !moved && ok; c++) begin
        @(posedge clk);
        #1;
        moved = (int'(point_x) != old_x) || (int'(point_y) != old_y);
      end
      if (!moved) ok = 1'b0;
    end
    check("multi_hit_progress", int'(ok), 1);
    @(negedge clk);
    check("score_final", int'(score), exp_score);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
